msk_and_sched: RTL and testbench

Round-robin scheduler sharing one bank of W masked HPC2 AND gadgets (output-side variant, `MSKand_hpc2o`, 2-cycle latency) between two requesters in the masked S-box datapath. It accepts share-wise operand pairs through valid/ready handshakes and gates each issue on fresh randomness from the PRNG. It splits operand delivery across the two cycles the gadget expects, tracks the owner of every in-flight operation and returns each result to its owner. One issue per cycle; no back-pressure on results.

---
 rtl/msk_and_sched.sv | 166 ++++++++++++++++
 tb/tb_msk_and_sched.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msk_and_sched.sv
// Round-robin scheduler sharing one bank of W masked HPC2 AND gadgets between two
// requesters; operands arrive share-wise and each issue consumes one fresh rnd word.

// Output-side HPC2 AND gadget, 2-cycle latency: ina and rnd are presented in the issue
// cycle, inb and ina_prev one cycle later, and the result lands one cycle after that.
module msk_and_hpc2o #(
    parameter int d = 2,
    parameter int W = 32
) (
    input  logic                     clk,
    input  logic [W*d-1:0]           ina,
    input  logic [W*d-1:0]           ina_prev,
    input  logic [W*d-1:0]           inb,
    input  logic [W*d*(d-1)/2-1:0]   rnd,
    output logic [W*d-1:0]           out
);
    localparam int RL = d*(d-1)/2;

    typedef logic [d-1:0][d-1:0] mat_t;

    mat_t         r_m   [W];
    mat_t         r_reg [W];
    mat_t         s_reg [W];
    mat_t         p_rnd [W];
    mat_t         p_crs [W];
    logic [d-1:0] p_dom [W];

    function automatic int pidx(input int i, input int j);
        return i*d - (i*(i+1))/2 + (j - i - 1);
    endfunction

    // r_ij = r_ji; the diagonal carries no randomness and stays zero.
    always_comb begin
        for (int l = 0; l < W; l++) begin
            for (int i = 0; i < d; i++) begin
                for (int j = 0; j < d; j++) begin
                    r_m[l][i][j] = 1'b0;
                    if (i < j)
                        r_m[l][i][j] = rnd[l*RL + pidx(i, j)];
                    else if (i > j)
                        r_m[l][i][j] = rnd[l*RL + pidx(j, i)];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < W; l++) begin
            for (int i = 0; i < d; i++) begin
                for (int j = 0; j < d; j++) begin
                    r_reg[l][i][j] <= r_m[l][i][j];
                    s_reg[l][i][j] <= (i == j) ? 1'b0 : (ina[l*d + j] ^ r_m[l][i][j]);
                end
            end
        end
    end

    // Every partial product is registered before any XOR so shares never meet in logic.
    always_ff @(posedge clk) begin
        for (int l = 0; l < W; l++) begin
            for (int i = 0; i < d; i++) begin
                p_dom[l][i] <= ina_prev[l*d + i] & inb[l*d + i];
                for (int j = 0; j < d; j++) begin
                    p_rnd[l][i][j] <= ~inb[l*d + i] & r_reg[l][i][j];
                    p_crs[l][i][j] <=  inb[l*d + i] & s_reg[l][i][j];
                end
            end
        end
    end

    always_comb begin
        logic acc;
        out = '0;
        for (int l = 0; l < W; l++) begin
            for (int i = 0; i < d; i++) begin
                acc = p_dom[l][i];
                for (int j = 0; j < d; j++)
                    acc = acc ^ p_rnd[l][i][j] ^ p_crs[l][i][j];
                out[l*d + i] = acc;
            end
        end
    end
endmodule

module msk_and_sched #(
    parameter int d   = 2,
    parameter int W   = 32,
    parameter int RND = W*d*(d-1)/2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [W*d-1:0]   in0_a,
    input  logic [W*d-1:0]   in0_b,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [W*d-1:0]   in1_a,
    input  logic [W*d-1:0]   in1_b,
    input  logic [RND-1:0]   rnd,
    input  logic             rnd_valid,
    output logic             rnd_ready,
    output logic             out0_valid,
    output logic             out1_valid,
    output logic [W*d-1:0]   out_data,
    output logic             busy
);
    localparam int N = W*d;

    logic         issue;
    logic         grant1;
    logic         prio;
    logic [N-1:0] ina_g;
    logic [N-1:0] a_reg;
    logic [N-1:0] b_reg;
    logic         v1, v2;
    logic         own1, own2;

    // Handshake: a transfer happens on a rising edge where valid & ready; ready is a
    // combinational function of both valids, rnd_valid and prio and never waits on itself.
    // rnd_ready pulses with every issue, so each rnd word feeds exactly one operation.
    always_comb begin
        grant1    = in1_valid & (~in0_valid | prio);
        issue     = rst_n & rnd_valid & (in0_valid | in1_valid);
        in0_ready = issue & ~grant1;
        in1_ready = issue & grant1;
        rnd_ready = issue;
        ina_g     = {N{issue}} & (grant1 ? in1_a : in0_a);
    end

    // Operand registers load only on issue so idle cycles never toggle stale shares.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            own1  <= 1'b0;
            own2  <= 1'b0;
            prio  <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            v1   <= issue;
            v2   <= v1;
            own2 <= own1;
            if (issue) begin
                own1  <= grant1;
                prio  <= ~grant1;
                a_reg <= ina_g;
                b_reg <= grant1 ? in1_b : in0_b;
            end
        end
    end

    msk_and_hpc2o #(.d(d), .W(W)) u_gadget (
        .clk      (clk),
        .ina      (ina_g),
        .ina_prev (a_reg),
        .inb      (b_reg),
        .rnd      (rnd),
        .out      (out_data)
    );

    assign out0_valid = v2 & ~own2;
    assign out1_valid = v2 & own2;
    assign busy       = v1 | v2;
endmodule

// File: tb/tb_msk_and_sched.sv
// Directed and randomized checks of the masked AND scheduler: grants, latency, reset
// discard, idle operand isolation and unmasked results against hand-computed values.
module tb_msk_and_sched;
    localparam int D   = 2;
    localparam int W   = 32;
    localparam int N   = W*D;
    localparam int RND = W*D*(D-1)/2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in0_valid = 1'b0, in1_valid = 1'b0;
    logic           in0_ready, in1_ready;
    logic [N-1:0]   in0_a = '0, in0_b = '0, in1_a = '0, in1_b = '0;
    logic [RND-1:0] rnd = '0;
    logic           rnd_valid = 1'b0;
    logic           rnd_ready;
    logic           out0_valid, out1_valid;
    logic [N-1:0]   out_data;
    logic           busy;

    msk_and_sched #(.d(D), .W(W), .RND(RND)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in0_valid  (in0_valid),
        .in0_ready  (in0_ready),
        .in0_a      (in0_a),
        .in0_b      (in0_b),
        .in1_valid  (in1_valid),
        .in1_ready  (in1_ready),
        .in1_a      (in1_a),
        .in1_b      (in1_b),
        .rnd        (rnd),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .out0_valid (out0_valid),
        .out1_valid (out1_valid),
        .out_data   (out_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, wanted %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] mask(input logic [W-1:0] x);
        logic [N-1:0] y;
        logic [W-1:0] m;
        m = $urandom;
        for (int i = 0; i < W; i++) begin
            y[i*D]     = x[i] ^ m[i];
            y[i*D + 1] = m[i];
        end
        return y;
    endfunction

    function automatic logic [W-1:0] unmask(input logic [N-1:0] y);
        logic [W-1:0] x;
        for (int i = 0; i < W; i++)
            x[i] = y[i*D] ^ y[i*D + 1];
        return x;
    endfunction

    // Reference pipeline and scoreboard
    logic [W:0]   exp_q[$];
    logic [W-1:0] cur_e0 = '0, cur_e1 = '0;
    logic         m_prio = 0, m_v1 = 0, m_v2 = 0, m_own1 = 0, m_own2 = 0;
    logic [N-1:0] prev_a = '0, prev_b = '0;
    logic         prev_issue = 0, prev_rst = 0;
    int           acc_cnt = 0, rr_cnt = 0;

    logic         s_rdy0, s_rdy1, s_rrdy, s_out0, s_out1, s_busy;
    logic [W-1:0] s_data;

    task automatic set_op(input bit k, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] e);
        if (k) begin
            in1_a = mask(a); in1_b = mask(b); cur_e1 = e; in1_valid = 1'b1;
        end else begin
            in0_a = mask(a); in0_b = mask(b); cur_e0 = e; in0_valid = 1'b1;
        end
    endtask

    // One clock: sample and check mid-cycle, advance the model, return just after the edge.
    task automatic tick();
        logic       e0, e1, iss;
        logic [W:0] ent;
        @(negedge clk);
        e0  = rst_n & rnd_valid & in0_valid & (~in1_valid | ~m_prio);
        e1  = rst_n & rnd_valid & in1_valid & (~in0_valid | m_prio);
        iss = e0 | e1;
        s_rdy0 = in0_ready; s_rdy1 = in1_ready; s_rrdy = rnd_ready;
        s_out0 = out0_valid; s_out1 = out1_valid; s_busy = busy;
        s_data = unmask(out_data);
        check("in0_ready", in0_ready, e0);
        check("in1_ready", in1_ready, e1);
        check("rnd_ready", rnd_ready, iss);
        check("out0_valid", out0_valid, m_v2 & ~m_own2);
        check("out1_valid", out1_valid, m_v2 & m_own2);
        check("busy", busy, m_v1 | m_v2);
        if (out0_valid | out1_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_out", 1, 0);
            end else begin
                ent = exp_q.pop_front();
                check("sb_owner", out1_valid, ent[W]);
                check("sb_data", s_data, ent[W-1:0]);
            end
        end
        if (!iss)
            check("idle_ina_zero", dut.ina_g, 0);
        if (!prev_issue && prev_rst) begin
            check("idle_a_hold", dut.a_reg, prev_a);
            check("idle_b_hold", dut.b_reg, prev_b);
        end
        prev_a = dut.a_reg; prev_b = dut.b_reg; prev_issue = iss; prev_rst = rst_n;
        acc_cnt += int'(in0_valid & in0_ready) + int'(in1_valid & in1_ready);
        rr_cnt  += int'(rnd_ready);
        if (iss)
            exp_q.push_back(e1 ? {1'b1, cur_e1} : {1'b0, cur_e0});
        if (!rst_n) begin
            m_v1 = 0; m_v2 = 0; m_own1 = 0; m_own2 = 0; m_prio = 0;
            exp_q.delete();
        end else begin
            m_v2 = m_v1; m_own2 = m_own1; m_v1 = iss; m_own1 = e1;
            if (iss) m_prio = e0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic rand_req(input bit k, input logic acc);
        logic         v;
        logic [W-1:0] a, b;
        v = k ? in1_valid : in0_valid;
        if (v && !acc) begin
            if ($urandom_range(0, 15) == 0) begin
                if (k) in1_valid = 1'b0; else in0_valid = 1'b0;
            end
            return;
        end
        if ($urandom_range(0, 2) != 0) begin
            a = $urandom; b = $urandom;
            set_op(k, a, b, a & b);
        end else begin
            if (k) in1_valid = 1'b0; else in0_valid = 1'b0;
        end
    endtask

    logic [W-1:0] a0_t[3]  = '{32'hFFFF0000, 32'h12345678, 32'hAAAAAAAA};
    logic [W-1:0] b0_t[3]  = '{32'h00FF00FF, 32'hF0F0F0F0, 32'hFFFFFFFF};
    logic [W-1:0] e0_t[3]  = '{32'h00FF0000, 32'h10305070, 32'hAAAAAAAA};
    logic [W-1:0] a1_t[3]  = '{32'h0000FFFF, 32'hDEADBEEF, 32'h55555555};
    logic [W-1:0] b1_t[3]  = '{32'hFFFFFFFF, 32'h0F0F0F0F, 32'h33333333};
    logic [W-1:0] e1_t[3]  = '{32'h0000FFFF, 32'h0E0D0E0F, 32'h11111111};
    logic [W-1:0] seq_t[6] = '{32'h00FF0000, 32'h0000FFFF, 32'h10305070,
                               32'h0E0D0E0F, 32'hAAAAAAAA, 32'h11111111};

    initial begin
        int i0, i1;
        // Reset entry; outputs are unknown before the first reset edge.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tick();
        check("reset_busy", s_busy, 0);
        check("reset_out0", s_out0, 0);
        check("reset_out1", s_out1, 0);
        rst_n = 1'b1;

        // Single op from requester 0
        set_op(0, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000);
        rnd = $urandom; rnd_valid = 1'b1;
        tick();
        check("t1_accept", s_rdy0, 1);
        in0_valid = 1'b0; rnd_valid = 1'b0;
        tick();
        check("t1_busy_t1", s_busy, 1);
        check("t1_out0_t1", s_out0, 0);
        tick();
        check("t1_out0_t2", s_out0, 1);
        check("t1_out1_t2", s_out1, 0);
        check("t1_data", s_data, 32'h0F0F0000);
        check("t1_busy_t2", s_busy, 1);
        tick();
        check("t1_out0_t3", s_out0, 0);
        check("t1_busy_t3", s_busy, 0);

        // Continuous contention: grants alternate starting with requester 0
        do_reset();
        i0 = 0; i1 = 0;
        set_op(0, a0_t[0], b0_t[0], e0_t[0]);
        set_op(1, a1_t[0], b1_t[0], e1_t[0]);
        rnd_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rnd = $urandom;
            tick();
            if (k < 6) begin
                check($sformatf("t2_grant0_%0d", k), s_rdy0, (k % 2) == 0);
                check($sformatf("t2_grant1_%0d", k), s_rdy1, (k % 2) == 1);
            end
            if (k >= 2) begin
                check($sformatf("t2_out0_%0d", k), s_out0, (k % 2) == 0);
                check($sformatf("t2_data_%0d", k), s_data, seq_t[k-2]);
            end
            if (s_rdy0) begin
                i0++;
                if (i0 < 3) set_op(0, a0_t[i0], b0_t[i0], e0_t[i0]); else in0_valid = 1'b0;
            end
            if (s_rdy1) begin
                i1++;
                if (i1 < 3) set_op(1, a1_t[i1], b1_t[i1], e1_t[i1]); else in1_valid = 1'b0;
            end
            if (k == 5) rnd_valid = 1'b0;
        end

        // Starved randomness stalls the requester
        do_reset();
        set_op(1, 32'hCAFEBABE, 32'hFFFF0000, 32'hCAFE0000);
        rnd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t3_no_ready", s_rdy1, 0);
            check("t3_no_rnd_ready", s_rrdy, 0);
            check("t3_no_out", s_out1, 0);
        end
        rnd = $urandom; rnd_valid = 1'b1;
        tick();
        check("t3_accept", s_rdy1, 1);
        check("t3_rnd_ready", s_rrdy, 1);
        in1_valid = 1'b0; rnd_valid = 1'b0;
        tick();
        tick();
        check("t3_out1", s_out1, 1);
        check("t3_data", s_data, 32'hCAFE0000);

        // Reset while two ops are in flight, leaving prio pointing at requester 1
        set_op(1, 32'h00000003, 32'h00000001, 32'h00000001);
        rnd = $urandom; rnd_valid = 1'b1;
        tick();
        check("t4_accept1", s_rdy1, 1);
        in1_valid = 1'b0;
        set_op(0, 32'h0000000C, 32'h00000004, 32'h00000004);
        rnd = $urandom;
        tick();
        check("t4_accept0", s_rdy0, 1);
        in0_valid = 1'b0; rnd_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("t4_no_out0", s_out0, 0);
            check("t4_no_out1", s_out1, 0);
            check("t4_busy", s_busy, 0);
        end
        set_op(0, 32'hF00000F0, 32'hFF0000FF, 32'hF00000F0);
        set_op(1, 32'h0F0F0F0F, 32'hFFFF0000, 32'h0F0F0000);
        rnd = $urandom; rnd_valid = 1'b1;
        tick();
        check("t4_post_reset_grant0", s_rdy0, 1);
        check("t4_post_reset_grant1", s_rdy1, 0);
        in0_valid = 1'b0;
        rnd = $urandom;
        tick();
        check("t4_second_grant1", s_rdy1, 1);
        in1_valid = 1'b0; rnd_valid = 1'b0;
        repeat (3) tick();

        // Random traffic against the scoreboard
        for (int c = 0; c < 10000; c++) begin
            rnd_valid = ($urandom_range(0, 3) != 0);
            rnd = $urandom;
            tick();
            rand_req(0, s_rdy0);
            rand_req(1, s_rdy1);
        end
        in0_valid = 1'b0; in1_valid = 1'b0; rnd_valid = 1'b0;
        repeat (3) tick();

        check("rnd_ready_vs_accepts", rr_cnt, acc_cnt);
        check("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
